// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO result registers (MULT, MULTU, DIV, DIVU, MTHI/MTLO).
// Iterative radix-2 datapath; FAST_MUL=1 computes the product in one cycle instead.
//
// state | meaning
// IDLE  | waiting for start; HI/LO hold the last result
// RUN   | one shift-add or restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction and HI/LO write-back
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

  stateT            state;
  logic             isDiv;
  logic             negRes;
  logic             negRem;
  logic             divZeroFlag;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             signedOp, aNeg, bNeg;
  logic [WIDTH-1:0] absA, absB;
  logic [2*WIDTH-1:0] fastProd;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] divSub;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0] quoFix, remFix;

  assign signedOp = ~op[0];
  assign aNeg     = signedOp & a_i[WIDTH-1];
  assign bNeg     = signedOp & b_i[WIDTH-1];
  assign absA     = aNeg ? -a_i : a_i;
  assign absB     = bNeg ? -b_i : b_i;
  assign fastProd = {{WIDTH{1'b0}}, absA} * {{WIDTH{1'b0}}, absB};

  // Multiply: {acc, mq} shifts right, adding the multiplicand when the low multiplier bit is set.
  assign mulSum   = {1'b0, acc} + (mq[0] ? {1'b0, opB} : '0);

  // Divide: acc is the partial remainder, mq shifts dividend bits out and quotient bits in.
  assign divShift = {acc, mq[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, opB};
  assign divSub   = divShift[WIDTH-1:0] - opB;

  assign prodFix  = negRes ? -{acc, mq} : {acc, mq};
  assign quoFix   = negRes ? -mq : mq;
  assign remFix   = negRem ? -acc : acc;

  assign busy = (state != IDLE);
  assign hi_o = hiReg;
  assign lo_o = loReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      isDiv       <= 1'b0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      divZeroFlag <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      mq          <= '0;
      opB         <= '0;
      hiReg       <= '0;
      loReg       <= '0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (hi_we) hiReg <= hi_wdata;
      if (lo_we) loReg <= lo_wdata;

      case (state)
        IDLE: begin
          if (start && !cancel) begin
            isDiv       <= op[1];
            negRes      <= aNeg ^ bNeg;
            negRem      <= aNeg;
            divZeroFlag <= op[1] && (b_i == '0);
            cnt         <= CW'(WIDTH - 1);
            if (op[1]) begin
              acc   <= '0;
              mq    <= absA;
              opB   <= absB;
              state <= (b_i == '0) ? FIX : RUN;
            end else if (FAST_MUL) begin
              {acc, mq} <= fastProd;
              opB       <= absA;
              state     <= FIX;
            end else begin
              acc   <= '0;
              mq    <= absB;
              opB   <= absA;
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (isDiv) begin
              acc <= divFits ? divSub : divShift[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], divFits};
            end else begin
              acc <= mulSum[WIDTH:1];
              mq  <= {mulSum[0], mq[WIDTH-1:1]};
            end
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end

        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            done     <= 1'b1;
            div_zero <= divZeroFlag;
            // Result write is placed after the direct writes so it wins on a shared edge.
            if (!divZeroFlag) begin
              if (isDiv) begin
                hiReg <= remFix;
                loReg <= quoFix;
              end else begin
                {hiReg, loReg} <= prodFix;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: iterative and FAST_MUL instances share stimulus,
// expected HI/LO/div_zero come from a plain-arithmetic 64-bit reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int ACT_NONE   = 0;
  localparam int ACT_START2 = 1;
  localparam int ACT_CANCEL = 2;
  localparam int ACT_RST    = 3;
  localparam int ACT_LOWE   = 4;

  typedef struct packed {
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } expT;

  logic         clk = 1'b0;
  logic         rst, start, cancel, hiWe, loWe;
  logic [1:0]   op;
  logic [W-1:0] aIn, bIn, hiWdata, loWdata;
  logic         busy, done, divZero;
  logic [W-1:0] hiO, loO;
  logic         fBusy, fDone, fDivZero;
  logic [W-1:0] fHiO, fLoO;

  expT qSlow[$];
  expT qFast[$];
  int  checks = 0;
  int  errors = 0;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_i(aIn), .b_i(bIn),
    .cancel(cancel), .hi_we(hiWe), .lo_we(loWe), .hi_wdata(hiWdata), .lo_wdata(loWdata),
    .busy(busy), .done(done), .div_zero(divZero), .hi_o(hiO), .lo_o(loO)
  );

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dutFast (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_i(aIn), .b_i(bIn),
    .cancel(cancel), .hi_we(hiWe), .lo_we(loWe), .hi_wdata(hiWdata), .lo_wdata(loWdata),
    .busy(fBusy), .done(fDone), .div_zero(fDivZero), .hi_o(fHiO), .lo_o(fLoO)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: full-width products and C-style truncating division on 64-bit integers.
  function automatic expT model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] h, input logic [W-1:0] l);
    expT e;
    longint sx, sy;
    logic [63:0] p;
    e.dz = 1'b0;
    e.hi = h;
    e.lo = l;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin p = sx * sy; {e.hi, e.lo} = p; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; {e.hi, e.lo} = p; end
      2'b10: begin
        if (y == 0) e.dz = 1'b1;
        else begin e.lo = 32'(sx / sy); e.hi = 32'(sx % sy); end
      end
      default: begin
        if (y == 0) e.dz = 1'b1;
        else begin e.lo = x / y; e.hi = x % y; end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin : monSlow
    expT e;
    if (done === 1'b1) begin
      if (qSlow.size() == 0) check("slow unexpected done", 1, 0);
      else begin
        e = qSlow.pop_front();
        check("slow hi", hiO, e.hi);
        check("slow lo", loO, e.lo);
        check("slow div_zero", divZero, e.dz);
      end
    end else if (divZero === 1'b1) check("slow div_zero without done", 1, 0);
  end

  always @(negedge clk) begin : monFast
    expT e;
    if (fDone === 1'b1) begin
      if (qFast.size() == 0) check("fast unexpected done", 1, 0);
      else begin
        e = qFast.pop_front();
        check("fast hi", fHiO, e.hi);
        check("fast lo", fLoO, e.lo);
        check("fast div_zero", fDivZero, e.dz);
      end
    end else if (fDivZero === 1'b1) check("fast div_zero without done", 1, 0);
  end

  // Issues one op at the next edge (edge 0) and watches cycles 1..40 after it.
  task automatic runOp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int expLat, input int fastLat, input int act, input int actCyc);
    expT e;
    int seenS, seenF, nS, nF;
    e = model(o, x, y, modelHi, modelLo);
    if (expLat > 0)  qSlow.push_back(e);
    if (fastLat > 0) qFast.push_back(e);
    start = 1'b1; op = o; aIn = x; bIn = y;
    @(posedge clk); #1;
    start = 1'b0;
    seenS = -1; seenF = -1; nS = 0; nF = 0;
    for (int c = 1; c <= 40; c++) begin
      start  = (act == ACT_START2 && c == actCyc);
      if (start) begin aIn = ~x; bIn = y + 32'd3; end
      cancel = (act == ACT_CANCEL && c == actCyc);
      rst    = (act == ACT_RST && c == actCyc);
      loWe   = (act == ACT_LOWE && c == actCyc);
      @(negedge clk);
      if (done === 1'b1)  begin nS++; if (seenS < 0) seenS = c; end
      if (fDone === 1'b1) begin nF++; if (seenF < 0) seenF = c; end
      if (c == 1 && expLat > 2) check("busy in cycle 1", busy, 1);
      if (expLat > 0 && c == expLat - 1) check("busy before done", busy, 1);
      if (expLat > 0 && c == expLat) check("busy with done", busy, 0);
      if ((act == ACT_CANCEL || act == ACT_RST) && c == actCyc + 1) begin
        check("busy after abort", busy, 0);
        check("done after abort", done, 0);
        if (act == ACT_RST) begin
          check("hi after rst", hiO, 0);
          check("lo after rst", loO, 0);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; cancel = 1'b0; rst = 1'b0; loWe = 1'b0;
    check("slow done count", nS, (expLat > 0) ? 1 : 0);
    if (expLat > 0) check("slow latency", seenS, expLat);
    check("fast done count", nF, (fastLat > 0) ? 1 : 0);
    if (fastLat > 0) check("fast latency", seenF, fastLat);
    if (act == ACT_RST) begin
      modelHi = '0; modelLo = '0;
    end else if (expLat > 0 && !e.dz) begin
      modelHi = e.hi; modelLo = e.lo;
    end
    check("slow hi held", hiO, modelHi);
    check("slow lo held", loO, modelLo);
  endtask

  function automatic int slowLat(input logic [1:0] o, input logic [W-1:0] y);
    return (o[1] && y == 0) ? 2 : 34;
  endfunction

  function automatic int fastLatOf(input logic [1:0] o, input logic [W-1:0] y);
    return (!o[1] || y == 0) ? 2 : 34;
  endfunction

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    op = 2'b00; aIn = '0; bIn = '0; hiWdata = '0; loWdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_zero", divZero, 0);
    check("reset hi", hiO, 0);
    check("reset lo", loO, 0);
    check("reset fast busy", fBusy, 0);
    @(posedge clk); #1;

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 2, ACT_NONE, 0);
    runOp(2'b00, -32'sd3, 32'd5, 34, 2, ACT_NONE, 0);
    runOp(2'b10, -32'sd7, 32'd2, 34, 34, ACT_NONE, 0);
    runOp(2'b11, 32'd7, 32'd2, 34, 34, ACT_NONE, 0);
    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34, 34, ACT_NONE, 0);

    hiWe = 1'b1; hiWdata = 32'h11; loWe = 1'b1; loWdata = 32'h22;
    @(posedge clk); #1;
    hiWe = 1'b0; loWe = 1'b0; loWdata = 32'hDEAD_BEEF;
    modelHi = 32'h11; modelLo = 32'h22;
    @(negedge clk);
    check("preset hi", hiO, 32'h11);
    check("preset lo", loO, 32'h22);
    @(posedge clk); #1;
    runOp(2'b11, 32'd5, 32'd0, 2, 2, ACT_NONE, 0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 40)) - 32'd20;
      case ($urandom_range(0, 7))
        0:       ry = '0;
        1:       ry = 32'hFFFF_FFFF;
        2:       ry = 32'($urandom_range(1, 17));
        default: ry = $urandom;
      endcase
      runOp(ro, rx, ry, slowLat(ro, ry), fastLatOf(ro, ry), ACT_NONE, 0);
    end

    runOp(2'b11, 32'd100, 32'd7, 34, 34, ACT_START2, 5);
    runOp(2'b10, 32'd1000, 32'd7, -1, -1, ACT_CANCEL, 10);

    start = 1'b1; cancel = 1'b1; op = 2'b11; aIn = 32'd9; bIn = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("start with cancel ignored", busy, 0);
    check("fast start with cancel ignored", fBusy, 0);
    repeat (40) @(posedge clk);
    #1;

    runOp(2'b00, 32'd123, -32'sd45, -1, 2, ACT_RST, 5);
    runOp(2'b00, 32'd7, 32'd9, 34, 2, ACT_LOWE, 33);
    @(negedge clk);
    check("slow lo result beats lo_we", loO, 32'd63);
    check("fast lo from lo_we", fLoO, 32'hDEAD_BEEF);
    check("fast hi kept", fHiO, 32'd0);
    check("slow queue drained", qSlow.size(), 0);
    check("fast queue drained", qFast.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width (even, >= 8).
REQ-002 SHALL provide parameter FAST_MUL, default 0; 0 = iterative multiply, 1 = single-cycle multiply.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request an operation; sampled only in IDLE.
REQ-007 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 a_i  in  WIDTH  multiplicand/dividend, captured with start.
REQ-009 b_i  in  WIDTH  multiplier/divisor, captured with start.
REQ-010 cancel  in  1  abort in-flight operation (pipeline flush).
REQ-011 hi_we, lo_we  in  1 each  direct HI/LO write (MTHI/MTLO).
REQ-012 hi_wdata, lo_wdata  in  WIDTH each  direct write data.
REQ-013 busy  out  1  operation in progress; pipeline stall request.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 div_zero  out  1  pulses with done when a divide had b_i = 0.
REQ-016 hi_o, lo_o  out  WIDTH each  HI/LO register contents (MFHI/MFLO).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FIX; busy = 1 in RUN and FIX only.
REQ-018 IDLE: start=1 and cancel=0 -> capture op/a_i/b_i, convert signed operands to magnitudes, go RUN (FIX if FAST_MUL multiply or divide by zero).
REQ-019 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); exactly WIDTH cycles, then FIX.
REQ-020 FIX: one cycle; apply sign correction, write HI/LO at the closing edge, go IDLE with done=1 in the following cycle.
REQ-021 Latency: start sampled at edge 0 -> done=1 during cycle WIDTH+2 (34 for WIDTH=32); FAST_MUL multiply and divide-by-zero -> done during cycle 2.
REQ-022 When done=1, hi_o/lo_o SHALL already hold the result; busy=0 in the same cycle; a new start is accepted that cycle.
REQ-023 Multiply: {HI,LO} = full 2*WIDTH-bit product, signed (MULT) or unsigned (MULTU).
REQ-024 Divide: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-025 Signed overflow (a_i = most-negative, b_i = -1): LO = most-negative, HI = 0, no error flag.
REQ-026 Divide by zero: HI/LO unchanged, div_zero=1 with done.
REQ-027 start while busy SHALL be ignored (no queueing).
REQ-028 cancel=1 in RUN/FIX: next state IDLE, HI/LO unchanged, no done, no div_zero; cancel+start in IDLE: start ignored.
REQ-029 hi_we/lo_we SHALL update HI/LO at the next edge in any state; on the same edge as a FIX result write, the result wins.
REQ-030 done and div_zero SHALL be registered outputs, never combinational from inputs.

Reset
REQ-031 rst=1 at an edge: state IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0, operand/iteration registers cleared.
REQ-032 rst SHALL take priority over start, cancel, hi_we, lo_we, and abort any operation mid-RUN with no done.

Verification (WIDTH=32, FAST_MUL=0 unless noted)
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy cycles 1-33, done in cycle 34, HI=0xFFFFFFFE, LO=0x00000001; with FAST_MUL=1 -> done in cycle 2, same values.
REQ-034 MULT -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, div_zero=0.
REQ-036 HI=0x11, LO=0x22 preset via hi_we/lo_we; DIVU 5/0 -> done in cycle 2, div_zero=1, HI=0x11, LO=0x22.
REQ-037 cancel in cycle 10 of a DIV -> busy=0 in cycle 11, no done pulse, HI/LO unchanged; second start during RUN ignored (one done only).
REQ-038 rst in cycle 5 of a MULT -> next cycle busy=0, HI=LO=0, no done; lo_we with FIX edge -> LO = result.
